// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states, transaction
// owner and the full-word byte-enable constant.
package mem_port_arbiter_pkg;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_RSP = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data ports.
// Data wins ties, but a streak counter forces an IF grant after MAX_DM_STREAK.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned STREAK_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req,
  input  logic [DATA_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [DATA_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  input  logic [3:0]            i_dm_be,
  output logic                  o_dm_gnt,
  output logic                  o_dm_rvalid,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;

  logic rsp;
  logic can_issue;
  logic sel_dm;
  logic gnt;

  // A response only counts while something is outstanding; strays in IDLE drop.
  assign rsp       = (state_q == ST_WAIT_RSP) && i_mem_rvalid;
  assign can_issue = (state_q == ST_IDLE) || rsp;
  assign sel_dm    = i_dm_req && (!i_if_req || (streak_q != STREAK_MAX));

  assign o_mem_en = can_issue && (i_if_req || i_dm_req);
  assign gnt      = o_mem_en && i_mem_ready;
  assign o_if_gnt = gnt && !sel_dm;
  assign o_dm_gnt = gnt && sel_dm;

  assign o_if_rvalid = rsp && (owner_q == OWN_IF);
  assign o_dm_rvalid = rsp && (owner_q == OWN_DM);
  assign o_if_rdata  = i_mem_rdata;
  assign o_dm_rdata  = i_mem_rdata;

  // NOTE: every output is given a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_be    = '0;
    if (sel_dm) begin
      o_mem_we    = i_dm_we;
      o_mem_addr  = i_dm_addr;
      o_mem_wdata = i_dm_wdata;
      o_mem_be    = i_dm_be;
    end else if (i_if_req) begin
      o_mem_addr = i_if_addr;
      o_mem_be   = BE_WORD;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    if (gnt) begin
      state_d = ST_WAIT_RSP;
      owner_d = sel_dm ? OWN_DM : OWN_IF;
    end else if (rsp) begin
      state_d = ST_IDLE;
    end
    // The streak only measures DM grants taken while IF is actually waiting.
    if (!i_if_req || o_if_gnt) begin
      streak_d = '0;
    end else if (o_dm_gnt && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

endmodule
